// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM states and the default byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } tx_feed_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port and transmitter handshake of the UART TX feeder.
interface uart_tx_feeder_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [DATA_W-1:0] dintx;
    logic              send;
    logic              donetx;
    logic              busy;

    // Feeder side.
    modport slave (
        input  wr_en, wr_data, donetx,
        output full, empty, level, overflow, dintx, send, busy
    );

    // Host / transmitter side.
    modport master (
        output wr_en, wr_data, donetx,
        input  full, empty, level, overflow, dintx, send, busy
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO. The caller must only write when !full or while
// popping in the same cycle, and only pop when !empty.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Storage: no reset needed, occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH; empty is registered off the count, so a
    // freshly written byte sits one cycle before it is offered for popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            empty <= (level == '0);
        end
    end

    assign full    = (level == FULL_LVL);
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them to the UART transmitter one at a time,
// pacing on donetx so no byte is lost or sent twice across the rate gap.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_feeder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    tx_feed_state_t    state, state_nx;
    logic              done_q;
    logic              rise;
    logic              pop;
    logic              wr_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_level;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] dintx_q;
    logic              overflow_q;
    logic              send_c;
    logic              busy_c;

    assign rise  = bus.donetx && !done_q;
    assign pop   = (state == IDLE) && !fifo_empty;
    // A full FIFO still takes a byte when a pop frees a slot on the same edge.
    assign wr_ok = bus.wr_en && (!fifo_full || pop);

    uart_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // State register and donetx edge-detect flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= bus.donetx;
        end
    end

    // Next state: send drops on the donetx rise, and we wait for donetx to fall
    // so the next request cannot be mistaken for the previous completion.
    always_comb begin
        state_nx = state;
        send_c   = 1'b0;
        busy_c   = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (!fifo_empty) state_nx = WAIT;
            end
            WAIT: begin
                send_c = 1'b1;
                if (rise) state_nx = CLEAR;
            end
            CLEAR: begin
                if (!bus.donetx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output byte latched at pop; held after completion.
    always_ff @(posedge clk) begin
        if (rst)      dintx_q <= '0;
        else if (pop) dintx_q <= head;
    end

    // Sticky flag for refused host writes.
    always_ff @(posedge clk) begin
        if (rst)                         overflow_q <= 1'b0;
        else if (bus.wr_en && !wr_ok)    overflow_q <= 1'b1;
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.level    = fifo_level;
    assign bus.overflow = overflow_q;
    assign bus.dintx    = dintx_q;
    assign bus.send     = send_c;
    assign bus.busy     = busy_c;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural slow transmitter.
module tb_uart_tx_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DATA_W(8), .DEPTH(16)) bus ();

    uart_tx_feeder #(.DATA_W(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: bit clock = clk/4. Samples send in idle, raises donetx
    // 10 bit clocks later, clears it on the first bit clock that sees send=0.
    logic [1:0] tick_cnt;
    int         bits;
    int         mst;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= 2'd0;
            bits       <= 0;
            mst        <= 0;
            bus.donetx <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + 2'd1;
            if (tick_cnt == 2'd3) begin
                case (mst)
                    0: if (bus.send) begin
                        rx_q.push_back(bus.dintx);
                        bits <= 0;
                        mst  <= 1;
                    end
                    1: if (bits == 9) begin
                        bus.donetx <= 1'b1;
                        mst        <= 2;
                    end else begin
                        bits <= bits + 1;
                    end
                    default: if (!bus.send) begin
                        bus.donetx <= 1'b0;
                        mst        <= 0;
                    end
                endcase
            end
        end
    end

    task automatic wait_idle(input string tag, input int n, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy && rx_q.size() == n && !bus.donetx) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_cnt"}, rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s_%0d", tag, k), (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_q[k]);
    endtask

    initial begin
        logic sent_after;
        logic ok;
        int   wi;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_full",  bus.full, 1'b0);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_level", bus.level, 0);
        check("rst_ovf",   bus.overflow, 1'b0);
        check("rst_send",  bus.send, 1'b0);
        check("rst_dintx", bus.dintx, 0);
        check("rst_busy",  bus.busy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte: write at edge N, send/dintx valid after N+2.
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("one_level_n",  bus.level, 1);
        check("one_send_n",   bus.send, 1'b0);
        @(negedge clk);
        check("one_send_n1",  bus.send, 1'b0);
        @(negedge clk);
        check("one_send_n2",  bus.send, 1'b1);
        check("one_dintx_n2", bus.dintx, 8'hA5);
        check("one_busy_n2",  bus.busy, 1'b1);
        wait_idle("one_done", 1, 400);
        check("one_empty", bus.empty, 1'b1);
        check("one_dhold", bus.dintx, 8'hA5);
        check_seq("one_seq");

        // Burst: 17 writes back to back; the first byte is popped during the
        // burst, leaving the FIFO exactly full.
        for (int i = 1; i <= 17; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i); exp_q.push_back(8'(i));
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("burst_level", bus.level, 16);
        check("burst_full",  bus.full, 1'b1);
        check("burst_ovf",   bus.overflow, 1'b0);
        check("burst_busy",  bus.busy, 1'b1);

        // Overflow: full, in WAIT, no pop possible.
        bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("ovf_set",   bus.overflow, 1'b1);
        check("ovf_level", bus.level, 16);
        repeat (3) @(negedge clk);
        check("ovf_sticky", bus.overflow, 1'b1);

        // Simultaneous: write in the IDLE cycle that pops from a full FIFO.
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("sim_reach_idle", ok, 1'b1);
        check("sim_full_pre", bus.full, 1'b1);
        bus.wr_en = 1'b1; bus.wr_data = 8'h12; exp_q.push_back(8'h12);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("sim_level", bus.level, 16);
        check("sim_busy",  bus.busy, 1'b1);
        check("sim_ovf",   bus.overflow, 1'b1);
        wait_idle("burst_drain", 19, 3000);
        check("drain_level", bus.level, 0);
        check("drain_empty", bus.empty, 1'b1);
        check("drain_ovf",   bus.overflow, 1'b1);
        check_seq("burst_seq");

        // Wrap: 40 bytes through the ring, written only when not full.
        wi = 0;
        for (int c = 0; c < 5000 && wi < 40; c++) begin
            if (!bus.full) begin
                bus.wr_en = 1'b1; bus.wr_data = 8'(wi * 37 + 5);
                exp_q.push_back(8'(wi * 37 + 5));
                wi++;
            end else begin
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("wrap_pushed", wi, 40);
        wait_idle("wrap_drain", 59, 4000);
        check("wrap_level", bus.level, 0);
        check_seq("wrap_seq");

        // Reset while in WAIT with 5 bytes queued.
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h31 + 8'(i);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("mid_level", bus.level, 5);
        check("mid_send",  bus.send, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_send",  bus.send, 1'b0);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_empty", bus.empty, 1'b1);
        check("mid_rst_busy",  bus.busy, 1'b0);
        check("mid_rst_ovf",   bus.overflow, 1'b0);
        rst = 1'b0;
        sent_after = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (bus.send || bus.busy) sent_after = 1'b1;
        end
        check("mid_no_resend", sent_after, 1'b0);
        check("mid_empty_end", bus.empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
